rom_read_arbiter: RTL and testbench

- Shares one synchronous ROM (4 words x 4 bits, `en`/`address` in, registered data out, one-cycle read latency) between NUM_REQ requesters.
- Uses round-robin arbitration and a 2-stage tagged read pipeline, so a new read can be issued every cycle.
- Sits between client blocks and the ROM instance, and is the only driver of the ROM `en` and `address` inputs.

---
 rtl/rom_read_arbiter.sv | 124 ++++++++++++
 tb/tb_rom_read_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between NUM_REQ clients.
// Ports:
//   clk, rst (async, active-low)
//   req / req_addr    : per-client read requests and packed addresses
//   gnt               : one-hot grant pulse (registered)
//   rsp_valid/rsp_data: one-hot response strobe and read data
//   rom_en/rom_address: registered ROM controls (sole driver)
//   rom_data_in       : ROM registered data output
//   busy              : any grant or read in flight
module rom_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_data_in,
    output logic                      busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [PW-1:0]      LAST  = PW'(NUM_REQ - 1);
    localparam logic [PW:0]        NREQ  = (PW+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_H = NUM_REQ'(1);

    logic [PW-1:0]        ptr;
    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [PW-1:0]        win;
    logic [PW:0]          sum;
    logic [PW-1:0]        ptr_nxt;
    logic [NUM_REQ-1:0]   win_oh;
    logic [ADDR_W-1:0]    win_addr;

    logic                 s1_v;
    logic [PW-1:0]        s1_tag;
    logic                 s2_v;
    logic [PW-1:0]        s2_tag;

    // A client granted this cycle sits out the next edge, so a
    // lone requester holding req high gets a fresh read every
    // other cycle.
    assign eligible = req & ~gnt;

    // Rotating priority search starting at ptr; the modulo is done
    // by a compare-and-subtract so NUM_REQ need not be a power of 2.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            if (!found && eligible[sum[PW-1:0]]) begin
                found = 1'b1;
                win   = sum[PW-1:0];
            end
        end
    end

    assign ptr_nxt  = (win == LAST) ? '0 : win + PW'(1);
    assign win_oh   = ONE_H << win;
    assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];

    // Grant stage: issues the ROM read and tags it with the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt         <= '0;
            rom_en      <= 1'b0;
            rom_address <= '0;
            s1_v        <= 1'b0;
            s1_tag      <= '0;
            ptr         <= '0;
        end else if (found) begin
            gnt         <= win_oh;
            rom_en      <= 1'b1;
            rom_address <= win_addr;
            s1_v        <= 1'b1;
            s1_tag      <= win;
            ptr         <= ptr_nxt;
        end else begin
            gnt         <= '0;
            rom_en      <= 1'b0;
            s1_v        <= 1'b0;
        end
    end

    // ROM-access stage: the ROM samples en/address on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v   <= 1'b0;
            s2_tag <= '0;
        end else begin
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
        end
    end

    // Response stage: ROM data is valid now; route it by tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (s2_v) begin
            rsp_valid <= ONE_H << s2_tag;
            rsp_data  <= rom_data_in;
        end else begin
            rsp_valid <= '0;
        end
    end

    assign busy = (|gnt) | s1_v | s2_v;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed vectors, a transaction-level
// reference model and literal checks against hand-computed values.
module tb_rom_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rom_en;
    logic [AW-1:0]   rom_address;
    logic [DW-1:0]   rom_data_in;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rom_mem [4] = '{4'h3, 4'h5, 4'h9, 4'hC};

    rom_read_arbiter #(
        .NUM_REQ(N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rom_en     (rom_en),
        .rom_address(rom_address),
        .rom_data_in(rom_data_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data_in <= rom_mem[rom_address];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: reads are a queue of (client, data, due cycle).
    typedef struct {
        int            tag;
        logic [DW-1:0] data;
        int            due;
    } pend_t;

    pend_t         q[$];
    int            cyc   = 0;
    int            m_ptr = 0;
    logic [N-1:0]  m_gnt = '0;
    logic          m_en  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [N-1:0]  m_rv  = '0;
    logic [DW-1:0] m_rd  = '0;

    initial forever begin
        logic [N-1:0] elig;
        int w;
        @(posedge clk or negedge rst);
        if (!rst) begin
            q.delete();
            m_ptr  = 0;
            m_gnt  = '0;
            m_en   = 1'b0;
            m_addr = '0;
            m_rv   = '0;
            m_rd   = '0;
        end else begin
            cyc++;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_rv = N'(1) << q[0].tag;
                m_rd = q[0].data;
                void'(q.pop_front());
            end else begin
                m_rv = '0;
            end
            elig = req & ~m_gnt;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_gnt  = N'(1) << w;
                m_en   = 1'b1;
                m_addr = req_addr[w*AW +: AW];
                q.push_back('{w, rom_mem[m_addr], cyc + 2});
                m_ptr  = (w + 1) % N;
            end else begin
                m_gnt = '0;
                m_en  = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("m_gnt", 32'(gnt), 32'(m_gnt));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("m_rsp_data", 32'(rsp_data), 32'(m_rd));
        chk("m_rom_en", 32'(rom_en), 32'(m_en));
        chk("m_rom_address", 32'(rom_address), 32'(m_addr));
        chk("m_busy", 32'(busy), 32'((m_gnt != 0) || (q.size() > 0)));
    end

    logic [N-1:0]  cg [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
    logic [DW-1:0] cd [7] = '{4'h3, 4'h5, 4'h9, 4'hC, 4'h3, 4'h5, 4'h9};

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rom_en", 32'(rom_en), 0);
        rst = 1'b1;

        // single request from client 0, address 2
        @(negedge clk);
        req = 4'b0001;
        req_addr = 8'h02;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_en", 32'(rom_en), 1);
        chk("single_addr", 32'(rom_address), 2);
        chk("single_busy0", 32'(busy), 1);
        req = '0;
        @(negedge clk);
        chk("single_gnt_off", 32'(gnt), 0);
        chk("single_busy1", 32'(busy), 1);
        @(negedge clk);
        chk("single_rv", 32'(rsp_valid), 32'h1);
        chk("single_rd", 32'(rsp_data), 32'h9);
        chk("single_busy2", 32'(busy), 0);

        // reset one cycle after a grant to client 2
        req = 4'b0100;
        req_addr = 8'h22;
        @(negedge clk);
        chk("rmid_gnt", 32'(gnt), 32'h4);
        req = '0;
        @(negedge clk);
        chk("rmid_busy_pre", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("rmid_gnt0", 32'(gnt), 0);
        chk("rmid_rv0", 32'(rsp_valid), 0);
        chk("rmid_rd0", 32'(rsp_data), 0);
        chk("rmid_en0", 32'(rom_en), 0);
        chk("rmid_addr0", 32'(rom_address), 0);
        chk("rmid_busy0", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;

        // all contend from ptr=0, addresses 0..3
        req = 4'hF;
        req_addr = 8'hE4;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("all_gnt", 32'(gnt), 32'(cg[k]));
            if (k >= 2) begin
                chk("all_rv", 32'(rsp_valid), 32'(cg[k-2]));
                chk("all_rd", 32'(rsp_data), 32'(cd[k-2]));
            end else begin
                chk("all_no_stale_rv", 32'(rsp_valid), 0);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);

        // fairness across wrap: ptr=3 after the last grant to client 2
        req = 4'b1001;
        @(negedge clk);
        chk("wrap_gnt3", 32'(gnt), 32'h8);
        @(negedge clk);
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        req = '0;
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        chk("wrap_ptr1", 32'(gnt), 32'h2);
        req = '0;
        repeat (3) @(negedge clk);

        // sole continuous requester: client 1 at address 3
        req = 4'b0010;
        req_addr = 8'hEC;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("sole_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 0);
            if (k >= 2) begin
                chk("sole_rv", 32'(rsp_valid), (k % 2 == 0) ? 32'h2 : 0);
                if (k % 2 == 0) chk("sole_rd", 32'(rsp_data), 32'hC);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);

        // withdrawal of client 1 and late address change on client 0
        req = 4'b1011;
        req_addr = 8'hE4;
        @(negedge clk);
        chk("wd_gnt3", 32'(gnt), 32'h8);
        req = 4'b1001;
        @(negedge clk);
        chk("wd_gnt0", 32'(gnt), 32'h1);
        req = '0;
        req_addr = 8'hE7;
        @(negedge clk);
        chk("wd_no_gnt1", 32'(gnt), 0);
        chk("wd_rv3", 32'(rsp_valid), 32'h8);
        chk("wd_rd3", 32'(rsp_data), 32'hC);
        req = 4'b0010;
        @(negedge clk);
        chk("wd_gnt1", 32'(gnt), 32'h2);
        chk("wd_rv0", 32'(rsp_valid), 32'h1);
        chk("wd_rd0_captured", 32'(rsp_data), 32'h3);
        req = '0;
        @(negedge clk);
        chk("wd_rv_gap", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("wd_rv1", 32'(rsp_valid), 32'h2);
        chk("wd_rd1", 32'(rsp_data), 32'h5);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
